// File: rtl/midi_msg_parser.sv
// MIDI channel voice message parser: running status, real-time
// interleave, SysEx skip; emits Note On/Off and CC events.
module midi_msg_parser #(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       DV,
  input  logic [7:0] DI,
  output logic       NOTE_ON,
  output logic       NOTE_OFF,
  output logic       CC,
  output logic       ERR,
  output logic [3:0] CH,
  output logic [6:0] KEY,
  output logic [6:0] VAL
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SYSEX
  } state_t;

  state_t     state, state_n;
  logic [7:0] rs, rs_n;
  logic       rs_vld, rs_vld_n;
  logic [6:0] d1, d1_n;
  logic       on_n, off_n, cc_n, err_n;
  logic [3:0] ch_n;
  logic [6:0] key_n, val_n;

  logic is_rt, is_stat, is_sys, take;
  logic two_byte, ch_ok;

  assign is_rt    = &DI[7:3];
  assign is_stat  = DI[7] & ~(&DI[6:4]);
  assign is_sys   = (&DI[7:4]) & ~DI[3];
  assign take     = DV & CE & ~is_rt;
  assign two_byte = (rs[6:4] != 3'd4) && (rs[6:4] != 3'd5);
  assign ch_ok    = OMNI || (rs[3:0] == 4'(CHANNEL));

  // Next-state, running status and event decode for one accepted byte
  always_comb begin
    state_n  = state;
    rs_n     = rs;
    rs_vld_n = rs_vld;
    d1_n     = d1;
    on_n     = 1'b0;
    off_n    = 1'b0;
    cc_n     = 1'b0;
    err_n    = 1'b0;
    ch_n     = CH;
    key_n    = KEY;
    val_n    = VAL;
    unique case (1'b1)
      !take: ;
      take && is_stat: begin
        rs_n     = DI;
        rs_vld_n = 1'b1;
        state_n  = WAIT_D1;
      end
      take && is_sys: begin
        rs_vld_n = 1'b0;
        state_n  = (DI == 8'hF0) ? SYSEX : IDLE;
      end
      take && !DI[7]: begin
        unique case (state)
          IDLE: err_n = 1'b1;
          WAIT_D1: begin
            if (rs_vld && two_byte) begin
              d1_n    = DI[6:0];
              state_n = WAIT_D2;
            end
          end
          WAIT_D2: begin
            state_n = WAIT_D1;
            if (ch_ok) begin
              unique case (rs[6:4])
                3'd0: off_n = 1'b1;
                3'd1: begin
                  on_n  = (DI[6:0] != 7'd0);
                  off_n = (DI[6:0] == 7'd0);
                end
                3'd3: cc_n = 1'b1;
                default: ;
              endcase
              if (on_n || off_n || cc_n) begin
                ch_n  = rs[3:0];
                key_n = d1;
                val_n = DI[6:0];
              end
            end
          end
          SYSEX: ;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State, message registers and output event registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rs       <= 8'h00;
      rs_vld   <= 1'b0;
      d1       <= 7'd0;
      NOTE_ON  <= 1'b0;
      NOTE_OFF <= 1'b0;
      CC       <= 1'b0;
      ERR      <= 1'b0;
      CH       <= 4'd0;
      KEY      <= 7'd0;
      VAL      <= 7'd0;
    end else begin
      state    <= state_n;
      rs       <= rs_n;
      rs_vld   <= rs_vld_n;
      d1       <= d1_n;
      NOTE_ON  <= on_n;
      NOTE_OFF <= off_n;
      CC       <= cc_n;
      ERR      <= err_n;
      CH       <= ch_n;
      KEY      <= key_n;
      VAL      <= val_n;
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: byte table plus
// sequences for CE gating, channel filter and mid-message reset.
module tb_midi_msg_parser;

  logic       clk, rst, ce, dv;
  logic [7:0] di;
  logic       on_a, off_a, cc_a, err_a;
  logic [3:0] ch_a;
  logic [6:0] key_a, val_a;
  logic       on_b, off_b, cc_b, err_b;
  logic [3:0] ch_b;
  logic [6:0] key_b, val_b;

  int errors = 0;
  int checks = 0;

  midi_msg_parser u_omni (
    .CLK(clk), .RST(rst), .CE(ce), .DV(dv), .DI(di),
    .NOTE_ON(on_a), .NOTE_OFF(off_a), .CC(cc_a), .ERR(err_a),
    .CH(ch_a), .KEY(key_a), .VAL(val_a)
  );

  midi_msg_parser #(.CHANNEL(2), .OMNI(1'b0)) u_filt (
    .CLK(clk), .RST(rst), .CE(ce), .DV(dv), .DI(di),
    .NOTE_ON(on_b), .NOTE_OFF(off_b), .CC(cc_b), .ERR(err_b),
    .CH(ch_b), .KEY(key_b), .VAL(val_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [21:0] mk(
    input logic on, input logic off, input logic cc, input logic er,
    input logic [3:0] ch, input logic [6:0] k, input logic [6:0] v);
    return {on, off, cc, er, ch, k, v};
  endfunction

  function automatic vec_t mv(input logic [7:0] b, input logic [21:0] e);
    vec_t r;
    r.b = b;
    r.exp = e;
    return r;
  endfunction

  function automatic logic [21:0] out_a();
    return {on_a, off_a, cc_a, err_a, ch_a, key_a, val_a};
  endfunction

  function automatic logic [21:0] out_b();
    return {on_b, off_b, cc_b, err_b, ch_b, key_b, val_b};
  endfunction

  task automatic chk(input string name, input logic [21:0] got,
                     input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got on/off/cc/err=%b ch=%h key=%h val=%h, want on/off/cc/err=%b ch=%h key=%h val=%h",
               name, got[21:18], got[17:14], got[13:7], got[6:0],
               exp[21:18], exp[17:14], exp[13:7], exp[6:0]);
    end
  endtask

  // One byte per cycle; outputs sampled 1 time unit after the edge
  task automatic send(input logic [7:0] b, input logic ce_v);
    @(negedge clk);
    di = b;
    dv = 1'b1;
    ce = ce_v;
    @(posedge clk);
    #1;
    dv = 1'b0;
    ce = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("reset_a", out_a(), 22'd0);
    chk("reset_b", out_b(), 22'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [21:0] Z = 22'd0;

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    dv  = 1'b0;
    di  = 8'h00;

    tbl.push_back(mv(8'h22, mk(0,0,0,1, 4'h0, 7'h00, 7'h00)));
    tbl.push_back(mv(8'h93, Z));
    tbl.push_back(mv(8'h3C, Z));
    tbl.push_back(mv(8'h64, mk(1,0,0,0, 4'h3, 7'h3C, 7'h64)));
    tbl.push_back(mv(8'h90, mk(0,0,0,0, 4'h3, 7'h3C, 7'h64)));
    tbl.push_back(mv(8'h40, mk(0,0,0,0, 4'h3, 7'h3C, 7'h64)));
    tbl.push_back(mv(8'h7F, mk(1,0,0,0, 4'h0, 7'h40, 7'h7F)));
    tbl.push_back(mv(8'h40, mk(0,0,0,0, 4'h0, 7'h40, 7'h7F)));
    tbl.push_back(mv(8'h00, mk(0,1,0,0, 4'h0, 7'h40, 7'h00)));
    tbl.push_back(mv(8'hB1, mk(0,0,0,0, 4'h0, 7'h40, 7'h00)));
    tbl.push_back(mv(8'hF8, mk(0,0,0,0, 4'h0, 7'h40, 7'h00)));
    tbl.push_back(mv(8'h07, mk(0,0,0,0, 4'h0, 7'h40, 7'h00)));
    tbl.push_back(mv(8'hFE, mk(0,0,0,0, 4'h0, 7'h40, 7'h00)));
    tbl.push_back(mv(8'h55, mk(0,0,1,0, 4'h1, 7'h07, 7'h55)));
    tbl.push_back(mv(8'h90, mk(0,0,0,0, 4'h1, 7'h07, 7'h55)));
    tbl.push_back(mv(8'h3C, mk(0,0,0,0, 4'h1, 7'h07, 7'h55)));
    tbl.push_back(mv(8'h80, mk(0,0,0,0, 4'h1, 7'h07, 7'h55)));
    tbl.push_back(mv(8'h3C, mk(0,0,0,0, 4'h1, 7'h07, 7'h55)));
    tbl.push_back(mv(8'h40, mk(0,1,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'hF0, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h01, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h02, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'hF7, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h3C, mk(0,0,0,1, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'hC5, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h10, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h11, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'hE2, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h00, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h40, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'hA4, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h30, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h31, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'hB7, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h0A, mk(0,0,0,0, 4'h0, 7'h3C, 7'h40)));
    tbl.push_back(mv(8'h7F, mk(0,0,1,0, 4'h7, 7'h0A, 7'h7F)));
    tbl.push_back(mv(8'h0B, mk(0,0,0,0, 4'h7, 7'h0A, 7'h7F)));
    tbl.push_back(mv(8'h01, mk(0,0,1,0, 4'h7, 7'h0B, 7'h01)));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_a", out_a(), Z);
    chk("reset_state_b", out_b(), Z);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].b, 1'b1);
      chk($sformatf("vec%0d_%h", i, tbl[i].b), out_a(), tbl[i].exp);
    end

    // CE gating: a byte offered with CE=0 is ignored
    send(8'h9F, 1'b1);
    send(8'h30, 1'b1);
    send(8'h31, 1'b0);
    chk("ce_ignored", out_a(), mk(0,0,0,0, 4'h7, 7'h0B, 7'h01));
    send(8'h70, 1'b1);
    chk("ce_note_on", out_a(), mk(1,0,0,0, 4'hF, 7'h30, 7'h70));
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #1;
    ce = 1'b1;
    chk("pulse_clear_ce0", out_a(), mk(0,0,0,0, 4'hF, 7'h30, 7'h70));

    // Channel filter on the CHANNEL=2 instance
    do_reset();
    send(8'h95, 1'b1);
    send(8'h3C, 1'b1);
    send(8'h64, 1'b1);
    chk("filt_other_ch", out_b(), Z);
    chk("omni_other_ch", out_a(), mk(1,0,0,0, 4'h5, 7'h3C, 7'h64));
    send(8'h92, 1'b1);
    send(8'h3C, 1'b1);
    send(8'h64, 1'b1);
    chk("filt_own_ch", out_b(), mk(1,0,0,0, 4'h2, 7'h3C, 7'h64));
    send(8'h25, 1'b1);
    send(8'h00, 1'b1);
    chk("filt_running_off", out_b(), mk(0,1,0,0, 4'h2, 7'h25, 7'h00));

    // Reset in the middle of a message
    send(8'h90, 1'b1);
    send(8'h3C, 1'b1);
    do_reset();
    send(8'h64, 1'b1);
    chk("rst_mid_err", out_a(), mk(0,0,0,1, 4'h0, 7'h00, 7'h00));
    send(8'h65, 1'b1);
    chk("rst_mid_err2", out_a(), mk(0,0,0,1, 4'h0, 7'h00, 7'h00));
    @(posedge clk);
    #1;
    chk("err_self_clear", out_a(), Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Byte-level MIDI message decoder that sits directly downstream of the MIDI UART receiver. It consumes the receiver's byte strobe and 8-bit data and assembles channel voice messages, handling running status and interleaved real-time bytes. It emits one-cycle Note On, Note Off and Control Change events with channel, key/controller number and velocity/value for the voice allocation logic.

## Interface

Parameters:
- CHANNEL, 0: MIDI channel (0–15) accepted when OMNI=0.
- OMNI, 1: 1 = accept all channels; 0 = emit events only for CHANNEL.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- CE  in  1  clock enable; bytes are accepted only when CE=1
- DV  in  1  byte-valid strobe from receiver, one CLK cycle per byte
- DI  in  8  received byte, valid when DV=1
- NOTE_ON  out  1  one-cycle pulse: Note On event
- NOTE_OFF  out  1  one-cycle pulse: Note Off event (includes Note On with velocity 0)
- CC  out  1  one-cycle pulse: Control Change event
- ERR  out  1  one-cycle pulse: orphan data byte discarded
- CH  out  4  channel of last event
- KEY  out  7  note number or controller number of last event
- VAL  out  7  velocity or controller value of last event

## Operation

- Byte accepted when DV & CE on a CLK rising edge. Other cycles: no state change.
- Registers: state, running status `rs[7:0]` with valid flag, first data byte `d1[6:0]`.
- States: IDLE (no valid running status), WAIT_D1, WAIT_D2, SYSEX.
- Real-time bytes 0xF8–0xFF: ignored in every state. No change to state, running status or outputs.
- Status byte 0x80–0xEF in any state: load `rs`, go to WAIT_D1. Any partial message is dropped without an event.
- System common 0xF0–0xF7:
  - Clears running status.
  - 0xF0 goes to SYSEX.
  - 0xF1–0xF7 go to IDLE.
- SYSEX: data bytes discarded. Any non-real-time status byte exits and is processed as above.
- Data byte (bit7=0):
  - IDLE: discarded, ERR pulse.
  - WAIT_D1, two-data-byte type (0x8n, 0x9n, 0xAn, 0xBn, 0xEn): store `d1`, go to WAIT_D2.
  - WAIT_D1, one-data-byte type (0xCn, 0xDn): message complete, no event, stay in WAIT_D1 (running status).
  - WAIT_D2: message complete, return to WAIT_D1 (running status). Event decode:
    - 0x8n → NOTE_OFF, KEY=d1, VAL=byte.
    - 0x9n with byte≠0 → NOTE_ON. 0x9n with byte=0 → NOTE_OFF with VAL=0.
    - 0xBn → CC, KEY=d1, VAL=byte.
    - 0xAn, 0xEn → no event.
- Channel filter: when OMNI=0 and `rs[3:0]`≠CHANNEL, messages are parsed normally but no event is emitted and CH/KEY/VAL do not change.
- CH/KEY/VAL update only when an event pulse is emitted, and hold until the next event.
- Only one event pulse can be high in any cycle.

## Timing

- Reset: async on RST rising. All outputs 0, state IDLE, `rs` invalid, `d1`=0. Reset mid-message discards the message.
- Latency: the event pulse and the new CH/KEY/VAL appear on the CLK edge that accepts the completing data byte. They are visible the following cycle, together.
- Pulses (NOTE_ON, NOTE_OFF, CC, ERR) are high exactly one CLK cycle. They self-clear on the next edge regardless of CE.
- Back-to-back DV on consecutive cycles must be handled with no byte loss.

## Test plan

- Basic Note On: bytes 0x93, 0x3C, 0x64 → single NOTE_ON, CH=3, KEY=0x3C, VAL=0x64; no other pulse.
- Running status and velocity-0 Note Off: 0x90, 0x40, 0x7F, 0x40, 0x00 → NOTE_ON (KEY=0x40, VAL=0x7F), then NOTE_OFF (KEY=0x40, VAL=0).
- Real-time interleave: 0xB1, 0xF8, 0x07, 0xFE, 0x55 → single CC, CH=1, KEY=0x07, VAL=0x55.
- Orphan, abort and SysEx:
  - After reset, byte 0x22 → ERR pulse.
  - 0x90, 0x3C, 0x80, 0x3C, 0x40 → only NOTE_OFF (KEY=0x3C, VAL=0x40).
  - 0xF0, 0x01, 0x02, 0xF7, 0x3C → ERR on 0x3C, no event.
- Channel filter (OMNI=0, CHANNEL=2): 0x95, 0x3C, 0x64 → no pulse, outputs unchanged; 0x92, 0x3C, 0x64 → NOTE_ON, CH=2.
- Reset mid-message: 0x90, 0x3C, assert RST, release, then 0x64 → ERR pulse, no NOTE_ON, all outputs 0 during reset.
